rs_array_sched: RTL and testbench

Sequencer for the 3x5 row-stationary PE array and its acc_row column adders.
- Fetches the 3x3 filter and the 7x7 ifmap from DRAM over a single-outstanding read handshake and loads them into the array.
- Runs the MAC phase and clears psums beforehand.
- Writes the 5x5 result back to DRAM in row-major order over a valid/ready write handshake.
- Sits between the DRAM port and the PE array inside the convolution top level.

---
 rtl/rs_array_sched.sv | 217 +++++++++++++++++++++
 tb/tb_rs_array_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_array_sched.sv
// rtl/rs_array_sched.sv - load/clear/compute/writeback sequencer for the 3x5 row-stationary PE array
// Optional RS_SCHED_CYCCNT_EN builds a saturating per-job cycle counter on cyc_cnt.
module rs_array_sched #(
  parameter int INWIDTH = 16,
  parameter int DI_W    = 7,
  parameter int DI_H    = 7,
  parameter int FIL_S   = 3,
  parameter int DO_W    = 5,
  parameter int DO_H    = 5,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_fil,
  input  logic [ADDR_W-1:0]  base_di,
  input  logic [ADDR_W-1:0]  base_do,
  output logic               busy,
  output logic               done,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_vld,
  input  logic [INWIDTH-1:0] rd_data,
  output logic [FIL_S-1:0]   fil_we,
  output logic [1:0]         fil_idx,
  output logic               di_we,
  output logic [2:0]         di_row,
  output logic [2:0]         di_col,
  output logic [INWIDTH-1:0] ld_data,
  output logic               pe_clr,
  output logic               pe_en,
  output logic [3:0]         mac_step,
  output logic [2:0]         res_row,
  output logic [2:0]         res_col,
  input  logic [INWIDTH-1:0] res_data,
  output logic               wr_vld,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INWIDTH-1:0] wr_data,
  input  logic               wr_rdy,
  output logic [15:0]        cyc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FIL, S_LOAD_DI, S_CLEAR, S_COMPUTE, S_WRITE, S_DONE
  } state_t;

  localparam int FIL_LAST  = FIL_S * FIL_S - 1;
  localparam int DI_LAST   = DI_W * DI_H - 1;
  localparam int WR_LAST   = DO_W * DO_H - 1;
  localparam int STEP_LAST = DO_W * FIL_S - 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [FIL_S-1:0]  FIL_ONE  = 1;

  state_t            state;
  logic [ADDR_W-1:0] di_base_q;
  logic [ADDR_W-1:0] do_base_q;
  logic [5:0]        cnt;
  logic [2:0]        row;
  logic [2:0]        col;
  logic              rd_take;

  assign rd_take = rd_req & rd_vld;

  // cnt is the linear word index; row/col track it so no divider is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      di_base_q <= '0;
      do_base_q <= '0;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      pe_clr    <= 1'b0;
      pe_en     <= 1'b0;
      mac_step  <= '0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            di_base_q <= base_di;
            do_base_q <= base_do;
            state     <= S_LOAD_FIL;
            busy      <= 1'b1;
            rd_req    <= 1'b1;
            rd_addr   <= base_fil;
            cnt       <= '0;
            row       <= '0;
            col       <= '0;
          end
        end
        S_LOAD_FIL: begin
          if (rd_take) begin
            if (cnt == 6'(FIL_LAST)) begin
              state   <= S_LOAD_DI;
              rd_addr <= di_base_q;
              cnt     <= '0;
              row     <= '0;
              col     <= '0;
            end else begin
              cnt     <= cnt + 6'd1;
              rd_addr <= rd_addr + ADDR_ONE;
              if (col == 3'(FIL_S - 1)) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        S_LOAD_DI: begin
          if (rd_take) begin
            if (cnt == 6'(DI_LAST)) begin
              state   <= S_CLEAR;
              rd_req  <= 1'b0;
              rd_addr <= '0;
              pe_clr  <= 1'b1;
              cnt     <= '0;
              row     <= '0;
              col     <= '0;
            end else begin
              cnt     <= cnt + 6'd1;
              rd_addr <= rd_addr + ADDR_ONE;
              if (col == 3'(DI_W - 1)) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        S_CLEAR: begin
          state    <= S_COMPUTE;
          pe_clr   <= 1'b0;
          pe_en    <= 1'b1;
          mac_step <= '0;
        end
        S_COMPUTE: begin
          if (mac_step == 4'(STEP_LAST)) begin
            state    <= S_WRITE;
            pe_en    <= 1'b0;
            mac_step <= '0;
            wr_vld   <= 1'b1;
            wr_addr  <= do_base_q;
          end else begin
            mac_step <= mac_step + 4'd1;
          end
        end
        S_WRITE: begin
          if (wr_rdy) begin
            if (cnt == 6'(WR_LAST)) begin
              state   <= S_DONE;
              wr_vld  <= 1'b0;
              wr_addr <= '0;
              done    <= 1'b1;
              cnt     <= '0;
              row     <= '0;
              col     <= '0;
            end else begin
              cnt     <= cnt + 6'd1;
              wr_addr <= wr_addr + ADDR_ONE;
              if (col == 3'(DO_W - 1)) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Load strobes follow rd_vld in the same cycle so the array captures rd_data directly.
  assign fil_we  = (state == S_LOAD_FIL && rd_take) ? (FIL_ONE << row) : '0;
  assign fil_idx = (state == S_LOAD_FIL) ? col[1:0] : 2'd0;
  assign di_we   = (state == S_LOAD_DI) && rd_take;
  assign di_row  = (state == S_LOAD_DI) ? row : 3'd0;
  assign di_col  = (state == S_LOAD_DI) ? col : 3'd0;
  assign ld_data = ((|fil_we) || di_we) ? rd_data : '0;
  assign res_row = wr_vld ? row : 3'd0;
  assign res_col = wr_vld ? col : 3'd0;
  assign wr_data = wr_vld ? res_data : '0;

`ifdef RS_SCHED_CYCCNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (state == S_IDLE) begin
      if (start) cyc_q <= '0;
    end else if (cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_q;
`else
  assign cyc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rs_array_sched.sv
// tb/tb_rs_array_sched.sv - directed self-checking bench for rs_array_sched
module tb_rs_array_sched;

`ifdef RS_SCHED_CYCCNT_EN
  localparam int CYC_EXP = 100;
`else
  localparam int CYC_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_fil = '0, base_di = '0, base_do = '0;
  logic        busy, done, rd_req;
  logic [7:0]  rd_addr;
  logic        rd_vld = 1'b0;
  logic [15:0] rd_data;
  logic [2:0]  fil_we;
  logic [1:0]  fil_idx;
  logic        di_we;
  logic [2:0]  di_row, di_col;
  logic [15:0] ld_data;
  logic        pe_clr, pe_en;
  logic [3:0]  mac_step;
  logic [2:0]  res_row, res_col;
  logic [15:0] res_data;
  logic        wr_vld;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_rdy = 1'b0;
  logic [15:0] cyc_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory and array models: data word encodes its address / result position.
  assign rd_data  = {8'hA5, rd_addr};
  assign res_data = {8'h5A, 1'b0, res_row, 1'b0, res_col};

  always #5 clk = ~clk;

  rs_array_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .base_fil(base_fil), .base_di(base_di), .base_do(base_do),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_vld(rd_vld), .rd_data(rd_data), .fil_we(fil_we), .fil_idx(fil_idx),
    .di_we(di_we), .di_row(di_row), .di_col(di_col), .ld_data(ld_data),
    .pe_clr(pe_clr), .pe_en(pe_en), .mac_step(mac_step),
    .res_row(res_row), .res_col(res_col), .res_data(res_data),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .cyc_cnt(cyc_cnt)
  );

  logic [7:0] rd_log[$];
  logic [2:0] fil_we_log[$];
  logic [1:0] fil_idx_log[$];
  logic [2:0] di_row_log[$], di_col_log[$];
  logic [7:0] wr_addr_log[$];
  logic [2:0] wr_row_log[$], wr_col_log[$];
  int clr_cnt, clr_cyc, en_cnt, en_first, step_viol, done_cnt, done_cyc, busy_cnt;
  int hold_viol, wr_hold_viol, bad_we, data_viol, stall_seen;
  logic [7:0] stall_addr;
  logic [2:0] stall_row, stall_col;

  // Drives one job from posedge+1 onward and logs everything the DUT emits.
  task automatic run_job(input bit rnd_rd, input int stall_n, input bit poke,
                         input int abort_m, input logic [7:0] bf, bd, bo);
    int cyc = 0;
    int after = 0;
    int stall_left = 10;
    int nrd, nwr;
    logic [7:0] exp_a;
    logic prev_rd_wait = 1'b0, prev_wr_wait = 1'b0;
    logic [7:0] prev_rd_addr = '0, prev_wr_addr = '0;
    rd_log.delete(); fil_we_log.delete(); fil_idx_log.delete();
    di_row_log.delete(); di_col_log.delete();
    wr_addr_log.delete(); wr_row_log.delete(); wr_col_log.delete();
    clr_cnt = 0; clr_cyc = -1; en_cnt = 0; en_first = -1; step_viol = 0;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; hold_viol = 0; wr_hold_viol = 0;
    bad_we = 0; data_viol = 0; stall_seen = 0;
    base_fil = bf; base_di = bd; base_do = bo;
    while (cyc < 600 && after < 6) begin
      if (abort_m >= 0 && di_row_log.size() == abort_m) begin
        rst = 1'b0;
        return;
      end
      start  = (cyc == 0) || (poke && (pe_en || done));
      rd_vld = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_rdy = 1'b1;
      if (stall_n >= 0 && wr_vld && wr_addr_log.size() == stall_n && stall_left > 0) begin
        wr_rdy = 1'b0;
        stall_left--;
        stall_seen++;
        stall_addr = wr_addr; stall_row = res_row; stall_col = res_col;
      end
      #1;
      if (rd_req) begin
        if (prev_rd_wait && rd_addr !== prev_rd_addr) hold_viol++;
        prev_rd_wait = !rd_vld;
        prev_rd_addr = rd_addr;
      end else begin
        prev_rd_wait = 1'b0;
      end
      if ((fil_we != 3'd0 || di_we) && !(rd_vld && rd_req)) bad_we++;
      nrd = rd_log.size();
      if (fil_we != 3'd0 || di_we) begin
        exp_a = (nrd < 9) ? bf + 8'(nrd) : bd + 8'(nrd - 9);
        if (ld_data !== {8'hA5, exp_a}) data_viol++;
      end
      if (rd_req && rd_vld) rd_log.push_back(rd_addr);
      if (fil_we != 3'd0) begin
        fil_we_log.push_back(fil_we);
        fil_idx_log.push_back(fil_idx);
      end
      if (di_we) begin
        di_row_log.push_back(di_row);
        di_col_log.push_back(di_col);
      end
      if (pe_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (pe_en) begin
        if (en_cnt == 0) en_first = cyc;
        if (mac_step !== 4'(cyc - en_first)) step_viol++;
        en_cnt++;
      end else if (mac_step !== 4'd0) begin
        step_viol++;
      end
      if (wr_vld) begin
        if (prev_wr_wait && wr_addr !== prev_wr_addr) wr_hold_viol++;
        prev_wr_wait = !wr_rdy;
        prev_wr_addr = wr_addr;
        if (wr_rdy) begin
          nwr = wr_addr_log.size();
          if (wr_data !== {8'h5A, 1'b0, 3'(nwr / 5), 1'b0, 3'(nwr % 5)}) data_viol++;
          wr_addr_log.push_back(wr_addr);
          wr_row_log.push_back(res_row);
          wr_col_log.push_back(res_col);
        end
      end else begin
        prev_wr_wait = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0) after++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; rd_vld = 1'b0; wr_rdy = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b exp 0", done); end
    n_cmp++; if (rd_req !== 1'b0 || rd_addr !== 8'd0) begin n_bad++; $display("FAIL reset_rd got %0b/%0h exp 0/0", rd_req, rd_addr); end
    n_cmp++; if (pe_en !== 1'b0 || pe_clr !== 1'b0 || wr_vld !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl got %0b%0b%0b exp 000", pe_en, pe_clr, wr_vld); end
    n_cmp++; if (cyc_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cyc got %0d exp 0", cyc_cnt); end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ideal;
    int errs = 0;
    logic [7:0] ea;
    run_job(1'b0, -1, 1'b0, -1, 8'd0, 8'd16, 8'd128);
    n_cmp++; if (fil_we_log.size() != 9) begin n_bad++; $display("FAIL ideal_fil_cnt got %0d exp 9", fil_we_log.size()); end
    for (int k = 0; k < 9 && k < fil_we_log.size(); k++)
      if (fil_we_log[k] !== 3'(1 << (k / 3)) || fil_idx_log[k] !== 2'(k % 3)) errs++;
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL ideal_fil_seq got %0d bad exp 0", errs); end
    errs = 0;
    for (int m = 0; m < 49 && m < di_row_log.size(); m++)
      if (di_row_log[m] !== 3'(m / 7) || di_col_log[m] !== 3'(m % 7)) errs++;
    n_cmp++; if (di_row_log.size() != 49 || errs != 0) begin n_bad++; $display("FAIL ideal_di got %0d writes %0d bad exp 49/0", di_row_log.size(), errs); end
    n_cmp++; if (di_row_log.size() == 49 && (di_row_log[48] !== 3'd6 || di_col_log[48] !== 3'd6)) begin n_bad++; $display("FAIL ideal_di_last got %0d,%0d exp 6,6", di_row_log[48], di_col_log[48]); end
    errs = 0;
    for (int i = 0; i < rd_log.size(); i++) begin
      ea = (i < 9) ? 8'(i) : 8'(16 + i - 9);
      if (rd_log[i] !== ea) errs++;
    end
    n_cmp++; if (rd_log.size() != 58 || errs != 0) begin n_bad++; $display("FAIL ideal_rd_addr got %0d words %0d bad exp 58/0", rd_log.size(), errs); end
    n_cmp++; if (clr_cnt != 1 || clr_cyc != 59) begin n_bad++; $display("FAIL ideal_clr got cnt %0d cyc %0d exp 1/59", clr_cnt, clr_cyc); end
    n_cmp++; if (en_cnt != 15 || en_first != 60 || step_viol != 0) begin n_bad++; $display("FAIL ideal_en got cnt %0d first %0d stepbad %0d exp 15/60/0", en_cnt, en_first, step_viol); end
    errs = 0;
    for (int n = 0; n < wr_addr_log.size(); n++)
      if (wr_addr_log[n] !== 8'(128 + n) || wr_row_log[n] !== 3'(n / 5) || wr_col_log[n] !== 3'(n % 5)) errs++;
    n_cmp++; if (wr_addr_log.size() != 25 || errs != 0) begin n_bad++; $display("FAIL ideal_wr got %0d writes %0d bad exp 25/0", wr_addr_log.size(), errs); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 100) begin n_bad++; $display("FAIL ideal_done got cnt %0d cyc %0d exp 1/100", done_cnt, done_cyc); end
    n_cmp++; if (busy_cnt != 100) begin n_bad++; $display("FAIL ideal_busy got %0d exp 100", busy_cnt); end
    n_cmp++; if (bad_we != 0 || data_viol != 0) begin n_bad++; $display("FAIL ideal_data got we %0d data %0d exp 0/0", bad_we, data_viol); end
    n_cmp++; if (cyc_cnt !== 16'(CYC_EXP)) begin n_bad++; $display("FAIL ideal_cyc_cnt got %0d exp %0d", cyc_cnt, CYC_EXP); end
  endtask

  task automatic test_rd_stall;
    int errs = 0;
    logic [7:0] ea;
    run_job(1'b1, -1, 1'b0, -1, 8'd0, 8'd16, 8'd128);
    for (int i = 0; i < rd_log.size(); i++) begin
      ea = (i < 9) ? 8'(i) : 8'(16 + i - 9);
      if (rd_log[i] !== ea) errs++;
    end
    n_cmp++; if (rd_log.size() != 58 || errs != 0) begin n_bad++; $display("FAIL rdst_words got %0d words %0d bad exp 58/0", rd_log.size(), errs); end
    n_cmp++; if (hold_viol != 0) begin n_bad++; $display("FAIL rdst_hold got %0d exp 0", hold_viol); end
    n_cmp++; if (bad_we != 0 || data_viol != 0) begin n_bad++; $display("FAIL rdst_we got we %0d data %0d exp 0/0", bad_we, data_viol); end
    n_cmp++; if (fil_we_log.size() != 9 || di_row_log.size() != 49 || done_cnt != 1) begin n_bad++; $display("FAIL rdst_counts got %0d/%0d/%0d exp 9/49/1", fil_we_log.size(), di_row_log.size(), done_cnt); end
  endtask

  task automatic test_wr_stall;
    int errs = 0;
    run_job(1'b0, 7, 1'b0, -1, 8'd0, 8'd16, 8'd128);
    n_cmp++; if (stall_seen != 10 || stall_addr !== 8'd135 || stall_row !== 3'd1 || stall_col !== 3'd2) begin n_bad++; $display("FAIL wrst_sel got %0d cyc addr %0d r%0d c%0d exp 10/135/1/2", stall_seen, stall_addr, stall_row, stall_col); end
    n_cmp++; if (wr_hold_viol != 0) begin n_bad++; $display("FAIL wrst_hold got %0d exp 0", wr_hold_viol); end
    for (int n = 0; n < wr_addr_log.size(); n++)
      if (wr_addr_log[n] !== 8'(128 + n)) errs++;
    n_cmp++; if (wr_addr_log.size() != 25 || errs != 0 || data_viol != 0) begin n_bad++; $display("FAIL wrst_seq got %0d writes %0d bad exp 25/0", wr_addr_log.size(), errs); end
    n_cmp++; if (done_cyc != 110) begin n_bad++; $display("FAIL wrst_done got %0d exp 110", done_cyc); end
  endtask

  task automatic test_start_ignored;
    run_job(1'b0, -1, 1'b1, -1, 8'd0, 8'd16, 8'd128);
    n_cmp++; if (done_cnt != 1 || done_cyc != 100) begin n_bad++; $display("FAIL poke_done got cnt %0d cyc %0d exp 1/100", done_cnt, done_cyc); end
    n_cmp++; if (busy !== 1'b0 || busy_cnt != 100) begin n_bad++; $display("FAIL poke_busy got %0b cnt %0d exp 0/100", busy, busy_cnt); end
  endtask

  task automatic test_abort;
    run_job(1'b0, -1, 1'b0, 20, 8'd0, 8'd16, 8'd128);
    #1;
    n_cmp++; if (busy !== 1'b0 || rd_req !== 1'b0 || rd_addr !== 8'd0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_ctrl got b%0b r%0b a%0h d%0b exp 0/0/0/0", busy, rd_req, rd_addr, done); end
    n_cmp++; if (di_we !== 1'b0 || fil_we !== 3'd0 || ld_data !== 16'd0) begin n_bad++; $display("FAIL abort_load got %0b/%0b/%0h exp 0/0/0", di_we, fil_we, ld_data); end
    rd_vld = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, -1, 1'b0, -1, 8'h40, 8'h60, 8'h80);
    n_cmp++; if (rd_log.size() == 0 || rd_log[0] !== 8'h40) begin n_bad++; $display("FAIL abort_restart got %0h exp 40", rd_log.size() ? rd_log[0] : 8'hxx); end
    n_cmp++; if (done_cnt != 1 || done_cyc != 100) begin n_bad++; $display("FAIL abort_done got cnt %0d cyc %0d exp 1/100", done_cnt, done_cyc); end
  endtask

  task automatic test_wrap;
    int errs = 0;
    run_job(1'b0, -1, 1'b0, -1, 8'd0, 8'd16, 8'hF0);
    for (int n = 0; n < wr_addr_log.size(); n++)
      if (wr_addr_log[n] !== 8'(8'hF0 + n)) errs++;
    n_cmp++; if (wr_addr_log.size() != 25 || errs != 0) begin n_bad++; $display("FAIL wrap_seq got %0d writes %0d bad exp 25/0", wr_addr_log.size(), errs); end
    n_cmp++; if (wr_addr_log.size() == 25 && (wr_addr_log[15] !== 8'hFF || wr_addr_log[16] !== 8'h00 || wr_addr_log[24] !== 8'h08)) begin n_bad++; $display("FAIL wrap_edges got %0h/%0h/%0h exp ff/00/08", wr_addr_log[15], wr_addr_log[16], wr_addr_log[24]); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_rd_stall();
    test_wr_stall();
    test_start_ignored();
    test_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
